// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a registered borrow.
// Processes one bit per clock, LSB first. done pulses once when D/Bout are updated.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             a_bit, b_bit, d_bit, br_nxt, last;

  assign a_bit  = sh_a[0];
  assign b_bit  = sh_b[0];
  assign d_bit  = a_bit ^ b_bit ^ borrow;
  assign br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sh_a   <= A;
          sh_b   <= B;
          borrow <= 1'b0;
          cnt    <= '0;
        end
        S_SHIFT: begin
          sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
          res    <= {d_bit, res[WIDTH-1:1]};
          borrow <= br_nxt;
          cnt    <= cnt + CW'(1);
          // Publish the completed word, including the bit computed this cycle.
          if (last) begin
            D    <= {d_bit, res[WIDTH-1:1]};
            Bout <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
